// File: rtl/bsg_fifo_rolly_tracker_mc.sv
// ---------------------------------------------------------------------------
// bsg_fifo_rolly_tracker_mc
//
// Pointer and occupancy tracker for a speculative ("rolly") FIFO. The enqueue
// and dequeue sides can each move several entries per cycle. The tracker sits
// next to a multi-ported RAM and supplies its addresses.
//
// It keeps four pointers. Each pointer is lg_size_p+1 bits wide, and the top
// bit is the wrap bit:
//   wptr  : speculative write pointer
//   wcptr : committed write pointer (the write checkpoint)
//   rptr  : speculative read pointer
//   rcptr : acknowledged read pointer (the read checkpoint)
//
// Writers can commit or drop speculative writes. Readers can ack speculative
// reads or roll them back.
//
// Handshake: this block has no valid/ready pair. The client must never ask
// for more than is legal:
//   - enq_cnt_i <= space_o
//   - deq_cnt_i <= avail_o
//   - counts within their maxima
// Violations are not blocked. They set the sticky error_o flag, and the
// pointers still update by the normal equations.
//
// Ports:
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   enq_cnt_i               entries written this cycle
//   deq_cnt_i               entries read this cycle
//   incr_cnt_i              entries advancing rcptr without an ack
//   commit_i / drop_i       commit or discard speculative writes
//   ack_i / rollback_i      acknowledge or rewind speculative reads
//   clr_i                   discard all unread data
//   wptr_r_o .. rcptr_r_o   registered pointer indices (no wrap bit)
//   rptr_n_o                next-cycle read index (combinational)
//   avail_o                 committed unread entries (wcptr - rptr)
//   space_o                 free slots (els - (wptr - rcptr))
//   full_o / empty_o        space_o == 0 / avail_o == 0
//   error_o                 sticky protocol violation flag
// ---------------------------------------------------------------------------
module bsg_fifo_rolly_tracker_mc #(
    parameter int lg_size_p   = 3,
    parameter int max_enq_p   = 1,
    parameter int max_deq_p   = 1,
    // Lets an environment that drives illegal traffic on purpose (to
    // exercise error_o) silence the protocol assertions.
    parameter bit assert_en_p = 1'b1,
    localparam int els = 1 << lg_size_p,
    localparam int ew  = $clog2(max_enq_p + 1),
    localparam int dw  = $clog2(max_deq_p + 1),
    localparam int cw  = lg_size_p + 1
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,

    input  logic [ew-1:0]        enq_cnt_i,
    input  logic [dw-1:0]        deq_cnt_i,
    input  logic [dw-1:0]        incr_cnt_i,

    input  logic                 commit_i,
    input  logic                 drop_i,
    input  logic                 ack_i,
    input  logic                 rollback_i,
    input  logic                 clr_i,

    output logic [lg_size_p-1:0] wptr_r_o,
    output logic [lg_size_p-1:0] wcptr_r_o,
    output logic [lg_size_p-1:0] rptr_r_o,
    output logic [lg_size_p-1:0] rcptr_r_o,
    output logic [lg_size_p-1:0] rptr_n_o,

    output logic [cw-1:0]        avail_o,
    output logic [cw-1:0]        space_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 error_o
);

    localparam logic [cw-1:0] els_c     = cw'(els);
    localparam logic [cw-1:0] max_enq_c = cw'(max_enq_p);
    localparam logic [cw-1:0] max_deq_c = cw'(max_deq_p);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [cw-1:0] wptr_r, wcptr_r, rptr_r, rcptr_r;
    logic [cw-1:0] wptr_n, wcptr_n, rptr_n, rcptr_n;
    logic          error_r, error_n;

    // Counts zero-extended to pointer width; all math is modulo 2^cw.
    logic [cw-1:0] enq_ext, deq_ext, incr_ext;
    logic [cw-1:0] rd_adv;     // rptr after this cycle's dequeue
    logic [cw-1:0] rc_adv;     // rcptr after this cycle's incr
    logic [cw-1:0] avail, space;

    assign enq_ext  = cw'(enq_cnt_i);
    assign deq_ext  = cw'(deq_cnt_i);
    assign incr_ext = cw'(incr_cnt_i);

    assign rd_adv = rptr_r  + deq_ext;
    assign rc_adv = rcptr_r + incr_ext;

    // Committed data readable now. Equal indices with equal wrap bits
    // give zero here, which is the empty case.
    assign avail = wcptr_r - rptr_r;

    // Occupancy is measured against rcptr, so entries that were read but
    // not yet acked still hold their slots. Equal indices with differing
    // wrap bits give a difference of els, which is the full case.
    assign space = els_c - (wptr_r - rcptr_r);

    // ------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------
    logic err_commit_drop;
    logic err_ack_mix;
    logic err_enq_space;
    logic err_deq_avail;
    logic err_rollback_deq;
    logic err_max;
    logic err_any;

    assign err_commit_drop  = commit_i & drop_i;
    assign err_ack_mix      = ack_i & (rollback_i | (incr_cnt_i != '0));
    assign err_enq_space    = (enq_ext > space);
    // A rollback cycle rewinds rptr, so its deq count is not checked
    // against avail here. A non-zero deq during rollback is caught by
    // err_rollback_deq instead.
    assign err_deq_avail    = (deq_ext > avail) & ~rollback_i;
    assign err_rollback_deq = rollback_i & (deq_cnt_i != '0);
    assign err_max          = (enq_ext  > max_enq_c)
                            | (deq_ext  > max_deq_c)
                            | (incr_ext > max_deq_c);

    assign err_any = err_commit_drop | err_ack_mix | err_enq_space
                   | err_deq_avail | err_rollback_deq | err_max;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        rptr_n  = rd_adv;
        rcptr_n = rc_adv;
        wptr_n  = wptr_r + enq_ext;
        wcptr_n = wcptr_r;
        error_n = error_r | err_any;

        if (rollback_i) begin
            rptr_n = rc_adv;
        end

        if (ack_i) begin
            rcptr_n = rd_adv;
        end

        // clr_i empties everything unread. The write side snaps to where
        // the read side is heading this cycle. Any enqueue, commit or drop
        // in the same cycle is discarded.
        if (clr_i) begin
            wptr_n  = rd_adv;
            wcptr_n = rd_adv;
        end else begin
            if (drop_i) begin
                wptr_n = wcptr_r;
            end
            if (commit_i) begin
                wcptr_n = wptr_r + enq_ext;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r  <= '0;
            wcptr_r <= '0;
            rptr_r  <= '0;
            rcptr_r <= '0;
            error_r <= 1'b0;
        end else begin
            wptr_r  <= wptr_n;
            wcptr_r <= wcptr_n;
            rptr_r  <= rptr_n;
            rcptr_r <= rcptr_n;
            error_r <= error_n;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wptr_r_o  = wptr_r[lg_size_p-1:0];
    assign wcptr_r_o = wcptr_r[lg_size_p-1:0];
    assign rptr_r_o  = rptr_r[lg_size_p-1:0];
    assign rcptr_r_o = rcptr_r[lg_size_p-1:0];
    assign rptr_n_o  = rptr_n[lg_size_p-1:0];

    assign avail_o = avail;
    assign space_o = space;
    assign full_o  = (space == '0);
    assign empty_o = (avail == '0);
    assign error_o = error_r;

    // ------------------------------------------------------------------
    // Simulation-only protocol assertions, one per error term
    // ------------------------------------------------------------------
    a_commit_drop: assert property (@(posedge clk_i)
        disable iff (!reset_n_i || !assert_en_p) !err_commit_drop)
        else $error("%m: commit_i and drop_i asserted together at time %0t", $time);

    a_ack_mix: assert property (@(posedge clk_i)
        disable iff (!reset_n_i || !assert_en_p) !err_ack_mix)
        else $error("%m: ack_i with rollback_i or incr_cnt_i at time %0t", $time);

    a_enq_space: assert property (@(posedge clk_i)
        disable iff (!reset_n_i || !assert_en_p) !err_enq_space)
        else $error("%m: enq_cnt_i exceeds space_o at time %0t", $time);

    a_deq_avail: assert property (@(posedge clk_i)
        disable iff (!reset_n_i || !assert_en_p) !err_deq_avail)
        else $error("%m: deq_cnt_i exceeds avail_o at time %0t", $time);

    a_rollback_deq: assert property (@(posedge clk_i)
        disable iff (!reset_n_i || !assert_en_p) !err_rollback_deq)
        else $error("%m: rollback_i with nonzero deq_cnt_i at time %0t", $time);

    a_max: assert property (@(posedge clk_i)
        disable iff (!reset_n_i || !assert_en_p) !err_max)
        else $error("%m: count above its maximum at time %0t", $time);

endmodule

// File: tb/tb_bsg_fifo_rolly_tracker_mc.sv
// ---------------------------------------------------------------------------
// Testbench for bsg_fifo_rolly_tracker_mc
// (lg_size_p=3, max_enq_p=max_deq_p=4)
//
// Every cycle goes through the task step(). step() does four things:
//   1. drives the inputs;
//   2. checks the combinational rptr_n_o against a small reference model;
//   3. pushes the model's packed registered outputs onto exp_q;
//   4. after the next rising edge, pops that entry and compares it with
//      the DUT outputs.
// The scenario tasks add checks against literal expected values.
// ---------------------------------------------------------------------------
module tb_bsg_fifo_rolly_tracker_mc;

    localparam int lg = 3;
    localparam int w  = 23;

    // ------------------------------------------------------------------
    // Clock / reset and DUT signals
    // ------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] enq_cnt, deq_cnt, incr_cnt;
    logic       commit, drop, ack, rollback, clr;
    logic [2:0] wptr_o, wcptr_o, rptr_o, rcptr_o, rptr_n_o;
    logic [3:0] avail_o, space_o;
    logic       full_o, empty_o, error_o;

    always #5 clk = ~clk;

    bsg_fifo_rolly_tracker_mc #(
        .lg_size_p  (lg),
        .max_enq_p  (4),
        .max_deq_p  (4),
        .assert_en_p(1'b0)
    ) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .enq_cnt_i  (enq_cnt),
        .deq_cnt_i  (deq_cnt),
        .incr_cnt_i (incr_cnt),
        .commit_i   (commit),
        .drop_i     (drop),
        .ack_i      (ack),
        .rollback_i (rollback),
        .clr_i      (clr),
        .wptr_r_o   (wptr_o),
        .wcptr_r_o  (wcptr_o),
        .rptr_r_o   (rptr_o),
        .rcptr_r_o  (rcptr_o),
        .rptr_n_o   (rptr_n_o),
        .avail_o    (avail_o),
        .space_o    (space_o),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .error_o    (error_o)
    );

    // ------------------------------------------------------------------
    // Scoreboard state and reference model
    // ------------------------------------------------------------------
    int           total = 0;
    int           bad   = 0;
    logic [w-1:0] exp_q[$];

    logic [3:0] m_w, m_wc, m_r, m_rc;
    logic       m_err;

    function automatic logic [3:0] m_avail();
        return m_wc - m_r;
    endfunction

    function automatic logic [3:0] m_space();
        return 4'd8 - (m_w - m_rc);
    endfunction

    function automatic logic [w-1:0] m_pack();
        logic [3:0] a, s;
        a = m_avail();
        s = m_space();
        return {m_w[2:0], m_wc[2:0], m_r[2:0], m_rc[2:0], a, s,
                (s == 4'd0), (a == 4'd0), m_err};
    endfunction

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic idle_inputs();
        enq_cnt  = '0;
        deq_cnt  = '0;
        incr_cnt = '0;
        commit   = 1'b0;
        drop     = 1'b0;
        ack      = 1'b0;
        rollback = 1'b0;
        clr      = 1'b0;
    endtask

    // Called at posedge+1. Drives one cycle and scoreboards it.
    task automatic step(input int e, input int d, input int i,
                        input bit cm, input bit dr, input bit ak,
                        input bit rb, input bit cl);
        logic [3:0]   ee, dd, ii, nr, nrc, nw, nwc;
        logic         bad_in;
        logic [w-1:0] exp_v, got_v;

        ee = 4'(e);
        dd = 4'(d);
        ii = 4'(i);

        enq_cnt  = 3'(e);
        deq_cnt  = 3'(d);
        incr_cnt = 3'(i);
        commit   = cm;
        drop     = dr;
        ack      = ak;
        rollback = rb;
        clr      = cl;

        nr  = rb ? (m_rc + ii) : (m_r + dd);
        nrc = ak ? (m_r + dd) : (m_rc + ii);
        nw  = cl ? (m_r + dd) : (dr ? m_wc : (m_w + ee));
        nwc = cl ? (m_r + dd) : (cm ? (m_w + ee) : m_wc);

        bad_in = (cm && dr) || (ak && (rb || i != 0)) || (ee > m_space())
              || ((dd > m_avail()) && !rb) || (rb && d != 0)
              || (e > 4) || (d > 4) || (i > 4);

        #1;
        total++;
        if (rptr_n_o !== nr[2:0]) begin
            bad++;
            $display("FAIL rptr_n: got %0d want %0d", rptr_n_o, nr[2:0]);
        end

        m_r   = nr;
        m_rc  = nrc;
        m_w   = nw;
        m_wc  = nwc;
        m_err = m_err | bad_in;
        exp_q.push_back(m_pack());

        @(posedge clk);
        #1;
        idle_inputs();

        exp_v = exp_q.pop_front();
        got_v = {wptr_o, wcptr_o, rptr_o, rcptr_o, avail_o, space_o,
                 full_o, empty_o, error_o};
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL outputs (w,wc,r,rc,avail,space,full,empty,err): got %0d,%0d,%0d,%0d,%0d,%0d,%0b,%0b,%0b want %0d,%0d,%0d,%0d,%0d,%0d,%0b,%0b,%0b",
                     wptr_o, wcptr_o, rptr_o, rcptr_o, avail_o, space_o,
                     full_o, empty_o, error_o,
                     exp_v[22:20], exp_v[19:17], exp_v[16:14], exp_v[13:11],
                     exp_v[10:7], exp_v[6:3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    // Resets the DUT and the model. Returns at posedge+1.
    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        m_w   = '0;
        m_wc  = '0;
        m_r   = '0;
        m_rc  = '0;
        m_err = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Scenario tasks
    // ------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (wptr_o !== 3'd0 || wcptr_o !== 3'd0 || rptr_o !== 3'd0 || rcptr_o !== 3'd0) begin
            bad++;
            $display("FAIL reset_ptrs: got %0d %0d %0d %0d want 0 0 0 0",
                     wptr_o, wcptr_o, rptr_o, rcptr_o);
        end
        total++;
        if (avail_o !== 4'd0 || space_o !== 4'd8) begin
            bad++;
            $display("FAIL reset_counts: got avail=%0d space=%0d want 0 8", avail_o, space_o);
        end
        total++;
        if (empty_o !== 1'b1 || full_o !== 1'b0 || error_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: got empty=%0b full=%0b err=%0b want 1 0 0",
                     empty_o, full_o, error_o);
        end
    endtask

    task automatic fill();
        step(4, 0, 0, 0, 0, 0, 0, 0);
        step(4, 0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic test_fill();
        do_reset();
        step(4, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (wptr_o !== 3'd4 || wcptr_o !== 3'd0 || avail_o !== 4'd0 || space_o !== 4'd4) begin
            bad++;
            $display("FAIL fill_spec: got w=%0d wc=%0d avail=%0d space=%0d want 4 0 0 4",
                     wptr_o, wcptr_o, avail_o, space_o);
        end
        step(4, 0, 0, 1, 0, 0, 0, 0);
        total++;
        if (wptr_o !== 3'd0 || wcptr_o !== 3'd0 || full_o !== 1'b1
            || space_o !== 4'd0 || avail_o !== 4'd8) begin
            bad++;
            $display("FAIL fill_full: got w=%0d wc=%0d full=%0b space=%0d avail=%0d want 0 0 1 0 8",
                     wptr_o, wcptr_o, full_o, space_o, avail_o);
        end
    endtask

    task automatic test_rollback();
        // Continues from the full state left by test_fill.
        step(0, 3, 0, 0, 0, 0, 0, 0);
        total++;
        if (rptr_o !== 3'd3 || rcptr_o !== 3'd0 || space_o !== 4'd0) begin
            bad++;
            $display("FAIL rb_deq1: got r=%0d rc=%0d space=%0d want 3 0 0",
                     rptr_o, rcptr_o, space_o);
        end
        step(0, 3, 0, 0, 0, 0, 0, 0);
        total++;
        if (rptr_o !== 3'd6 || rcptr_o !== 3'd0 || space_o !== 4'd0) begin
            bad++;
            $display("FAIL rb_deq2: got r=%0d rc=%0d space=%0d want 6 0 0",
                     rptr_o, rcptr_o, space_o);
        end
        // The rewind lands rptr on rcptr+incr. Without an ack, rcptr also
        // advances by incr.
        step(0, 0, 1, 0, 0, 0, 1, 0);
        total++;
        if (rptr_o !== 3'd1 || rcptr_o !== 3'd1 || avail_o !== 4'd7) begin
            bad++;
            $display("FAIL rb_rewind: got r=%0d rc=%0d avail=%0d want 1 1 7",
                     rptr_o, rcptr_o, avail_o);
        end
    endtask

    task automatic test_ack_drop();
        do_reset();
        fill();
        step(0, 2, 0, 0, 0, 1, 0, 0);
        total++;
        if (rptr_o !== 3'd2 || rcptr_o !== 3'd2 || space_o !== 4'd2 || avail_o !== 4'd6) begin
            bad++;
            $display("FAIL ack: got r=%0d rc=%0d space=%0d avail=%0d want 2 2 2 6",
                     rptr_o, rcptr_o, space_o, avail_o);
        end
        step(2, 0, 0, 0, 1, 0, 0, 0);
        total++;
        if (wptr_o !== 3'd0 || wcptr_o !== 3'd0 || space_o !== 4'd2 || error_o !== 1'b0) begin
            bad++;
            $display("FAIL drop: got w=%0d wc=%0d space=%0d err=%0b want 0 0 2 0",
                     wptr_o, wcptr_o, space_o, error_o);
        end
    endtask

    task automatic test_wrap_clr();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(4, 0, 0, 1, 0, 0, 0, 0);
            step(0, 4, 0, 0, 0, 1, 0, 0);
        end
        step(4, 0, 0, 1, 0, 0, 0, 0);   // w = wc = 16 (index 0)
        step(1, 0, 0, 1, 0, 0, 0, 0);   // w = wc = 17 (index 1)
        step(0, 2, 0, 0, 0, 1, 0, 0);   // r = rc = 14
        total++;
        if (rptr_o !== 3'd6 || wcptr_o !== 3'd1 || avail_o !== 4'd3) begin
            bad++;
            $display("FAIL wrap_setup: got r=%0d wc=%0d avail=%0d want 6 1 3",
                     rptr_o, wcptr_o, avail_o);
        end
        step(2, 0, 0, 0, 0, 0, 0, 0);   // speculative writes to be cleared
        // deq 3 crosses the wrap. clr overrides the commit and the enqueue.
        step(1, 3, 0, 1, 0, 0, 0, 1);
        total++;
        if (rptr_o !== 3'd1 || empty_o !== 1'b1 || avail_o !== 4'd0) begin
            bad++;
            $display("FAIL wrap_empty: got r=%0d empty=%0b avail=%0d want 1 1 0",
                     rptr_o, empty_o, avail_o);
        end
        total++;
        if (wptr_o !== 3'd1 || wcptr_o !== 3'd1 || error_o !== 1'b0) begin
            bad++;
            $display("FAIL wrap_clr: got w=%0d wc=%0d err=%0b want 1 1 0",
                     wptr_o, wcptr_o, error_o);
        end
    endtask

    task automatic test_error();
        do_reset();
        step(0, 0, 0, 1, 1, 0, 0, 0);
        total++;
        if (error_o !== 1'b1) begin
            bad++;
            $display("FAIL err_commit_drop: got %0b want 1", error_o);
        end
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (error_o !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky: got %0b want 1", error_o);
        end
        do_reset();
        total++;
        if (error_o !== 1'b0) begin
            bad++;
            $display("FAIL err_cleared: got %0b want 0", error_o);
        end
        step(4, 0, 0, 1, 0, 0, 0, 0);
        step(2, 0, 0, 1, 0, 0, 0, 0);
        total++;
        if (space_o !== 4'd2 || error_o !== 1'b0) begin
            bad++;
            $display("FAIL err_pre: got space=%0d err=%0b want 2 0", space_o, error_o);
        end
        step(3, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (error_o !== 1'b1) begin
            bad++;
            $display("FAIL err_overflow: got %0b want 1", error_o);
        end

        // Reset mid-burst, between clock edges.
        enq_cnt = 3'd1;
        commit  = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (wptr_o !== 3'd0 || wcptr_o !== 3'd0 || rptr_o !== 3'd0
            || avail_o !== 4'd0 || space_o !== 4'd8 || error_o !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got w=%0d wc=%0d r=%0d avail=%0d space=%0d err=%0b want 0 0 0 0 8 0",
                     wptr_o, wcptr_o, rptr_o, avail_o, space_o, error_o);
        end
        do_reset();
    endtask

    // Random legal traffic, checked only through the scoreboard.
    task automatic test_random();
        do_reset();
        for (int n = 0; n < 80; n++) begin
            int         sp, av, lim, e, d, i, mode;
            bit         cm, dr, ak, rb, cl;
            logic [3:0] diff;
            sp   = int'(m_space());
            av   = int'(m_avail());
            e    = $urandom_range(0, (sp > 4) ? 4 : sp);
            rb   = ($urandom_range(0, 7) == 0);
            d    = rb ? 0 : $urandom_range(0, (av > 4) ? 4 : av);
            ak   = !rb && ($urandom_range(0, 2) == 0);
            diff = m_r - m_rc;
            lim  = int'(diff);
            i    = ak ? 0 : $urandom_range(0, (lim > 4) ? 4 : lim);
            mode = $urandom_range(0, 5);
            cm   = (mode == 1) || (mode == 2) || (mode == 3);
            dr   = (mode == 4);
            cl   = ($urandom_range(0, 15) == 0);
            step(e, d, i, cm, dr, ak, rb, cl);
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence and final report
    // ------------------------------------------------------------------
    initial begin
        idle_inputs();
        reset_n = 1'b0;
        test_reset();
        test_fill();
        test_rollback();
        test_ack_drop();
        test_wrap_clr();
        test_error();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
